// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-requester RAM port arbiter.
package ram_arb_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances only when a grant is taken.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_p,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] grant
);

  logic favour_b;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = favour_b ? 2'b10 : 2'b01;
    end
  end

  // After a grant, the other requester gets priority on the next contention.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      favour_b <= 1'b0;
    end else if (update_en && (grant != 2'b00)) begin
      favour_b <= grant[0];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two requesters; one command in flight at a time.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_rdn_wr,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);

  arb_state_t state, state_next;
  logic [1:0] req;
  logic [1:0] grant;
  logic       accept;
  logic       cmd_wr;
  owner_t     cmd_owner;

  // Requests reach the arbiter only while idle and out of reset, so ready can never leak elsewhere.
  assign req     = ((state == IDLE) && !rst_p) ? {b_valid, a_valid} : 2'b00;
  assign a_ready = grant[0];
  assign b_ready = grant[1];
  assign accept  = grant[0] | grant[1];
  assign busy    = (state != IDLE);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_p     (rst_p),
    .req       (req),
    .update_en (accept),
    .grant     (grant)
  );

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = cmd_wr ? IDLE : RD_WAIT;
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The ram_* registers double as the command register; rdn_wr is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      ram_addr    <= '0;
      ram_data_in <= '0;
      ram_rdn_wr  <= 1'b0;
      cmd_wr      <= 1'b0;
      cmd_owner   <= OWNER_A;
    end else begin
      ram_rdn_wr <= 1'b0;
      if (accept) begin
        ram_addr    <= grant[1] ? b_addr : a_addr;
        ram_data_in <= grant[1] ? b_wdata : a_wdata;
        ram_rdn_wr  <= grant[1] ? b_wr : a_wr;
        cmd_wr      <= grant[1] ? b_wr : a_wr;
        cmd_owner   <= grant[1] ? OWNER_B : OWNER_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (state == RD_WAIT) begin
        if (cmd_owner == OWNER_A) begin
          a_rdata  <= ram_data_out;
          a_rvalid <= 1'b1;
        end else begin
          b_rdata  <= ram_data_out;
          b_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios followed by randomized traffic.
module tb_ram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_p;
  logic          a_valid, a_ready, a_wr, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_ready, b_wr, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic          ram_rdn_wr;
  logic          busy;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_p        (rst_p),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_wr         (a_wr),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_rvalid     (a_rvalid),
    .a_rdata      (a_rdata),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_wr         (b_wr),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_rvalid     (b_rvalid),
    .b_rdata      (b_rdata),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_rdn_wr   (ram_rdn_wr),
    .ram_data_out (ram_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle read latency, standing in for the real memory.
  logic [DW-1:0] ram_mem [0:65535];
  always @(posedge clk) begin
    if (ram_rdn_wr) ram_mem[ram_addr] <= ram_data_in;
    ram_data_out <= ram_mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_rd_t;

  cmd_t    q_a[$];
  cmd_t    q_b[$];
  exp_rd_t exp_a[$];
  exp_rd_t exp_b[$];

  // Reference model state: memory contents, who is favoured, when the port frees up.
  logic [DW-1:0] ref_mem [int];
  bit            fav_b;
  int            free_cyc;
  int            wr_cyc;
  logic [AW-1:0] wr_addr_exp;
  logic [DW-1:0] wr_data_exp;
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] last_a, last_b;

  int checks   = 0;
  int failures = 0;
  bit stall_flag = 1'b0;

  bit acc_a, acc_b;
  int gap_pct;

  function automatic logic [DW-1:0] ref_read(logic [AW-1:0] addr);
    return ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic check_return(bit is_b, logic rvalid, logic [DW-1:0] rdata);
    logic [DW-1:0] last;
    bit due;
    last = is_b ? last_b : last_a;
    due  = is_b ? (exp_b.size() > 0 && exp_b[0].due == cyc) : (exp_a.size() > 0 && exp_a[0].due == cyc);
    checkOutput(is_b ? "b_rvalid" : "a_rvalid", rvalid, due);
    if (due) begin
      last = is_b ? exp_b.pop_front().data : exp_a.pop_front().data;
      if (is_b) last_b = last; else last_a = last;
    end
    checkOutput(is_b ? "b_rdata" : "a_rdata", rdata, last);
  endtask

  task automatic monitor_cycle();
    int   win;
    bit   idle;
    cmd_t c;
    checkOutput("drain_timeout", stall_flag, 0);
    if (rst_p) begin
      checkOutput("a_ready_in_reset", a_ready, 0);
      checkOutput("b_ready_in_reset", b_ready, 0);
      fav_b     = 1'b0;
      free_cyc  = cyc + 1;
      wr_cyc    = -1;
      addr_hold = '0;
      last_a    = '0;
      last_b    = '0;
      exp_a.delete();
      exp_b.delete();
      return;
    end
    idle = (cyc >= free_cyc);
    win  = 0;
    if (idle) begin
      if (a_valid && b_valid) win = fav_b ? 2 : 1;
      else if (a_valid)       win = 1;
      else if (b_valid)       win = 2;
    end
    checkOutput("busy", busy, !idle);
    checkOutput("a_ready", a_ready, win == 1);
    checkOutput("b_ready", b_ready, win == 2);
    checkOutput("ram_rdn_wr", ram_rdn_wr, cyc == wr_cyc);
    checkOutput("ram_addr", ram_addr, addr_hold);
    if (cyc == wr_cyc) checkOutput("ram_data_in", ram_data_in, wr_data_exp);
    check_return(1'b0, a_rvalid, a_rdata);
    check_return(1'b1, b_rvalid, b_rdata);
    if (win != 0) begin
      c.wr    = (win == 1) ? a_wr : b_wr;
      c.addr  = (win == 1) ? a_addr : b_addr;
      c.wdata = (win == 1) ? a_wdata : b_wdata;
      fav_b     = (win == 1);
      addr_hold = c.addr;
      if (c.wr) begin
        ref_mem[int'(c.addr)] = c.wdata;
        wr_cyc      = cyc + 1;
        wr_addr_exp = c.addr;
        wr_data_exp = c.wdata;
        free_cyc    = cyc + 2;
      end else begin
        if (win == 1) exp_a.push_back('{cyc + 3, ref_read(c.addr)});
        else          exp_b.push_back('{cyc + 3, ref_read(c.addr)});
        free_cyc = cyc + 3;
      end
    end
  endtask

  always @(negedge clk) monitor_cycle();

  // One cycle of driving: drop valid after an accept, then maybe present the next queued command.
  task automatic applyStimulus();
    cmd_t c;
    @(negedge clk);
    acc_a = a_valid && a_ready;
    acc_b = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (acc_a) a_valid = 1'b0;
    if (acc_b) b_valid = 1'b0;
    if (!a_valid && q_a.size() > 0 && $urandom_range(99) >= gap_pct) begin
      c = q_a.pop_front();
      a_valid = 1'b1; a_wr = c.wr; a_addr = c.addr; a_wdata = c.wdata;
    end
    if (!b_valid && q_b.size() > 0 && $urandom_range(99) >= gap_pct) begin
      c = q_b.pop_front();
      b_valid = 1'b1; b_wr = c.wr; b_addr = c.addr; b_wdata = c.wdata;
    end
  endtask

  task automatic drain(int max_cycles);
    int n = 0;
    while ((q_a.size() > 0 || q_b.size() > 0 || a_valid || b_valid || busy ||
            exp_a.size() > 0 || exp_b.size() > 0) && n < max_cycles) begin
      applyStimulus();
      n++;
    end
    if (n >= max_cycles) stall_flag = 1'b1;
  endtask

  task automatic do_reset();
    rst_p = 1'b1;
    @(posedge clk);
    #1;
    rst_p = 1'b0;
  endtask

  function automatic cmd_t mk(logic wr, logic [AW-1:0] addr, logic [DW-1:0] wdata);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) ram_mem[i] = '0;
    rst_p   = 1'b1;
    gap_pct = 0;
    // Both requesters present reads while reset is held: neither may see ready.
    a_valid = 1'b1; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b1; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_p = 1'b0;
    drain(50);

    $display("[TB] single write then read-back on requester A");
    q_a.push_back(mk(1'b1, 16'h0010, 8'hA5));
    drain(50);
    q_a.push_back(mk(1'b0, 16'h0010, 8'h00));
    drain(50);

    $display("[TB] contention from reset alternates A,B");
    q_a.push_back(mk(1'b1, 16'h0001, 8'h11));
    q_b.push_back(mk(1'b1, 16'h0002, 8'h22));
    drain(50);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(mk(1'b0, 16'h0001, 8'h00));
      q_b.push_back(mk(1'b0, 16'h0002, 8'h00));
    end
    drain(100);

    $display("[TB] B alone for four commands");
    q_b.push_back(mk(1'b1, 16'h0040, 8'h5A));
    q_b.push_back(mk(1'b0, 16'h0040, 8'h00));
    q_b.push_back(mk(1'b1, 16'h0041, 8'hC3));
    q_b.push_back(mk(1'b0, 16'h0041, 8'h00));
    drain(100);

    $display("[TB] reset during RD_WAIT aborts the read");
    q_a.push_back(mk(1'b0, 16'h0010, 8'h00));
    n = 0;
    acc_a = 1'b0;
    while (!acc_a && n < 20) begin
      applyStimulus();
      n++;
    end
    if (n >= 20) stall_flag = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    q_a.push_back(mk(1'b0, 16'h0001, 8'h00));
    q_b.push_back(mk(1'b0, 16'h0002, 8'h00));
    drain(50);

    $display("[TB] top-of-range address");
    q_a.push_back(mk(1'b1, 16'hFFFF, 8'h3C));
    q_b.push_back(mk(1'b0, 16'hFFFF, 8'h00));
    drain(50);

    $display("[TB] randomized traffic");
    gap_pct = 40;
    for (int i = 0; i < 300; i++) begin
      cmd_t c;
      c.wr    = $urandom_range(1);
      c.addr  = ($urandom_range(9) == 0) ? 16'hFFFF : AW'($urandom_range(7));
      c.wdata = DW'($urandom);
      if ($urandom_range(1) == 1) q_b.push_back(c);
      else                        q_a.push_back(c);
    end
    drain(5000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_p  input  1  reset, synchronous, active-high.
REQ-005 a_valid / b_valid  input  1  requester A/B command valid.
REQ-006 a_ready / b_ready  output  1  requester A/B command accepted this cycle.
REQ-007 a_wr / b_wr  input  1  1 = write, 0 = read.
REQ-008 a_addr / b_addr  input  ADDR_WIDTH  command address.
REQ-009 a_wdata / b_wdata  input  DATA_WIDTH  write data.
REQ-010 a_rvalid / b_rvalid  output  1  one-cycle pulse, read data valid for A/B.
REQ-011 a_rdata / b_rdata  output  DATA_WIDTH  read data, held until next read completion for that requester.
REQ-012 ram_addr  output  ADDR_WIDTH  to RAM addr.
REQ-013 ram_data_in  output  DATA_WIDTH  to RAM data_in.
REQ-014 ram_rdn_wr  output  1  to RAM rdn_wr (0 read, 1 write).
REQ-015 ram_data_out  input  DATA_WIDTH  from RAM data_out; valid one cycle after a read is presented.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, ACCESS, RD_WAIT; reset state IDLE.
REQ-018 IDLE: if any valid, winner chosen by 2-way round-robin; winner's ready asserted combinationally same cycle; loser's ready low; next state ACCESS.
REQ-019 Round-robin: priority pointer favours the requester not granted last; both valid -> pointer side wins; only one valid -> it wins regardless of pointer.
REQ-020 Pointer updates only on a grant; reset value favours A.
REQ-021 Accepted command (wr, addr, wdata, owner) registered on the accept edge; driven on ram_* for exactly the ACCESS cycle.
REQ-022 ACCESS, write: ram_rdn_wr=1 one cycle; next state IDLE; no rvalid.
REQ-023 ACCESS, read: ram_rdn_wr=0; next state RD_WAIT.
REQ-024 RD_WAIT: ram_data_out captured into owner's rdata; owner's rvalid pulses the following cycle (registered); next state IDLE.
REQ-025 Read latency: accept edge to rvalid high = 3 cycles; write occupies 2 cycles, read 3 cycles, back-to-back.
REQ-026 ready never asserted outside IDLE; at most one ready high per cycle.
REQ-027 ram_rdn_wr SHALL be 0 in every cycle except ACCESS for a write; ram_addr/ram_data_in hold last values otherwise.
REQ-028 A valid held while not ready SHALL not be dropped; command fields sampled only on accept.
REQ-029 rvalid of one requester never coincides with rvalid of the other.
REQ-030 Address passed unmodified; no wrap or range check.

Reset
REQ-031 rst_p high at a rising edge: state IDLE, pointer favours A, ram_rdn_wr=0, ram_addr=0, ram_data_in=0, a/b_rvalid=0, a/b_rdata=0, busy=0.
REQ-032 rst_p during ACCESS or RD_WAIT aborts the command: no rvalid issued, no write after the reset edge.
REQ-033 a_ready/b_ready SHALL be 0 while rst_p is high.

Structure
REQ-034 Package ram_arb_pkg holds the state enum and default ADDR_WIDTH/DATA_WIDTH constants.
REQ-035 Round-robin choice implemented in sub-module rr_arb2 (2 requests in, one-hot grant out, pointer register inside, update enable input).

Verification
REQ-036 Reset, then A write addr 0x0010 data 0xA5 -> ram_rdn_wr=1 one cycle with addr 0x0010 data 0xA5; no rvalid.
REQ-037 A read addr 0x0010 after REQ-036 -> a_rvalid pulse 3 cycles after accept, a_rdata=0xA5, b_rvalid stays 0.
REQ-038 A and B valid continuously from reset (reads, addr 0x0001/0x0002) -> grants alternate A,B,A,B; each rvalid to correct owner.
REQ-039 Only B valid for 4 commands -> B granted each time, one grant per IDLE visit, no stall from pointer.
REQ-040 rst_p asserted in RD_WAIT of A read -> no a_rvalid, FSM IDLE, next grant to A.
REQ-041 Write to 0xFFFF data 0x3C then read 0xFFFF -> rdata 0x3C; ram_rdn_wr 0 on all non-write cycles.
